// File: rtl/arbitro_alu.sv
// rtl/arbitro_alu.sv - two-requester round-robin front end around a registered ALU
// Requests are arbitrated in IDLE, executed in EXEC and held in RESP until the consumer accepts.

module unidad_logico_aritmetica #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic [N-1:0] resultado,
  output logic         negativo,
  output logic         cero,
  output logic         overflow,
  output logic         carry
);

  logic [N:0] suma;
  logic [N:0] resta;

  // Subtraction as a + ~b + 1, so carry means "no borrow".
  assign suma  = {1'b0, a} + {1'b0, b};
  assign resta = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};

  always_comb begin
    resultado = '0;
    overflow  = 1'b0;
    carry     = 1'b0;
    case (ALUControl)
      4'b0000: resultado = a & b;
      4'b0001: resultado = a | b;
      4'b0010: resultado = a ^ b;
      4'b0011: resultado = ~(a | b);
      4'b0100: resultado = a << b;
      4'b0101: resultado = a >> b;
      4'b0110: resultado = $signed(a) >>> b;
      4'b0111: resultado = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1000: begin
        {carry, resultado} = suma;
        overflow = (a[N-1] == b[N-1]) && (suma[N-1] != a[N-1]);
      end
      4'b1001: begin
        {carry, resultado} = resta;
        overflow = (a[N-1] != b[N-1]) && (resta[N-1] != a[N-1]);
      end
      4'b1010: resultado = {{(N-1){1'b0}}, (a < b)};
      4'b1011: resultado = ~a;
      4'b1100: resultado = a;
      4'b1101: resultado = b;
      default: resultado = '0;
    endcase
  end

  assign negativo = resultado[N-1];
  assign cero     = (resultado == '0);

endmodule

module arbitro_alu #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  input  logic [3:0]   op0,
  input  logic [3:0]   op1,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resultado,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_v,
  output logic         flag_c,
  output logic         resp_err,
  output logic [7:0]   ops_cnt0,
  output logic [7:0]   ops_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;

  stateT        state, nextState;
  logic         prio;
  logic [N-1:0] aReg, bReg;
  logic [3:0]   opReg;
  logic         idReg;
  logic         anyReq;
  logic         grantId;
  logic         take;
  logic         done;
  logic         opErr;
  logic [N-1:0] aluRes;
  logic         aluN, aluZ, aluV, aluC;

  unidad_logico_aritmetica #(N) alu (
    aReg, bReg, opReg, aluRes, aluN, aluZ, aluV, aluC
  );

  // prio only matters when both request; a lone requester always wins.
  assign anyReq  = |req_valid;
  assign grantId = (req_valid == 2'b11) ? prio : req_valid[1];
  assign take    = (state == IDLE) && anyReq;
  assign done    = (state == RESP) && resp_ready;
  assign opErr   = (opReg >= 4'b1110);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState  = state;
    req_ready  = 2'b00;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) begin
          req_ready = grantId ? 2'b10 : 2'b01;
          nextState = EXEC;
        end
      end
      EXEC: nextState = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aReg  <= '0;
      bReg  <= '0;
      opReg <= '0;
      idReg <= 1'b0;
      prio  <= 1'b0;
    end else if (take) begin
      aReg  <= grantId ? a1 : a0;
      bReg  <= grantId ? b1 : b0;
      opReg <= grantId ? op1 : op0;
      idReg <= grantId;
      prio  <= ~grantId;
    end
  end

  // Response registers only load in EXEC, so they hold steady through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resultado <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_v    <= 1'b0;
      flag_c    <= 1'b0;
      resp_err  <= 1'b0;
      resp_id   <= 1'b0;
    end else if (state == EXEC) begin
      resultado <= opErr ? '0 : aluRes;
      flag_n    <= opErr ? 1'b0 : aluN;
      flag_z    <= opErr ? 1'b0 : aluZ;
      flag_v    <= opErr ? 1'b0 : aluV;
      flag_c    <= opErr ? 1'b0 : aluC;
      resp_err  <= opErr;
      resp_id   <= idReg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_cnt0 <= 8'h00;
      ops_cnt1 <= 8'h00;
    end else if (done) begin
      if (!resp_id && ops_cnt0 != 8'hFF) ops_cnt0 <= ops_cnt0 + 8'h01;
      if (resp_id && ops_cnt1 != 8'hFF)  ops_cnt1 <= ops_cnt1 + 8'h01;
    end
  end

endmodule

// File: tb/tb_arbitro_alu.sv
// tb/tb_arbitro_alu.sv - directed self-checking bench for arbitro_alu at N=4

module tb_arbitro_alu;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [N-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [3:0]   op0 = '0, op1 = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic         resp_id;
  logic [N-1:0] resultado;
  logic         flag_n, flag_z, flag_v, flag_c;
  logic         resp_err;
  logic [7:0]   ops_cnt0, ops_cnt1;
  logic [3:0]   flags;

  int numChecks = 0;
  int numFails  = 0;

  assign flags = {flag_n, flag_z, flag_v, flag_c};

  arbitro_alu #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resultado(resultado),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c),
    .resp_err(resp_err), .ops_cnt0(ops_cnt0), .ops_cnt1(ops_cnt1)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One isolated operation from IDLE with resp_ready high; returns in IDLE.
  task automatic runSingle(input string tag, input logic id, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] op, input logic [3:0] expRes, input logic [3:0] expFlags,
                           input logic [3:0] flagMask, input logic expErr);
    if (id) begin a1 = a; b1 = b; op1 = op; req_valid = 2'b10; end
    else    begin a0 = a; b0 = b; op0 = op; req_valid = 2'b01; end
    resp_ready = 1'b1;
    #1 checkVal({tag, ".grant"}, req_ready, id ? 2'b10 : 2'b01);
    step();
    req_valid = 2'b00;
    checkVal({tag, ".execValid"}, resp_valid, 1'b0);
    step();
    checkVal({tag, ".respValid"}, resp_valid, 1'b1);
    checkVal({tag, ".res"}, resultado, expRes);
    checkVal({tag, ".flags"}, flags & flagMask, expFlags & flagMask);
    checkVal({tag, ".err"}, resp_err, expErr);
    checkVal({tag, ".id"}, resp_id, id);
    step();
    checkVal({tag, ".idle"}, resp_valid, 1'b0);
  endtask

  initial begin
    int lastK;
    int nResp;
    logic expId;

    #1 rst = 1'b1;
    #1;
    checkVal("rst.respValid", resp_valid, 1'b0);
    checkVal("rst.reqReady", req_ready, 2'b00);
    checkVal("rst.res", resultado, 4'h0);
    checkVal("rst.flags", flags, 4'h0);
    checkVal("rst.id", resp_id, 1'b0);
    checkVal("rst.err", resp_err, 1'b0);
    checkVal("rst.cnt0", ops_cnt0, 8'h00);
    checkVal("rst.cnt1", ops_cnt1, 8'h00);
    step();
    step();
    rst = 1'b0;

    runSingle("and0", 1'b0, 4'b0111, 4'b1011, 4'b0000, 4'b0011, 4'b0000, 4'b1100, 1'b0);
    checkVal("and0.cnt0", ops_cnt0, 8'd1);
    runSingle("add1", 1'b1, 4'b0111, 4'b1011, 4'b1000, 4'b0010, 4'b0001, 4'b1111, 1'b0);
    runSingle("sub1", 1'b1, 4'b0111, 4'b1011, 4'b1001, 4'b1100, 4'b1010, 4'b1110, 1'b0);
    checkVal("sub1.cnt1", ops_cnt1, 8'd2);
    runSingle("err0", 1'b0, 4'b0111, 4'b1011, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    checkVal("err0.cnt0", ops_cnt0, 8'd2);
    runSingle("or1", 1'b1, 4'b0111, 4'b1011, 4'b0001, 4'b1111, 4'b1000, 4'b1100, 1'b0);
    runSingle("zero0", 1'b0, 4'b0101, 4'b0101, 4'b1001, 4'b0000, 4'b0100, 4'b1110, 1'b0);
    runSingle("err1", 1'b1, 4'b0011, 4'b0011, 4'b1110, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    checkVal("err1.cnt1", ops_cnt1, 8'd4);
    checkVal("err1.cnt0", ops_cnt0, 8'd3);

    // Consumer stalls 5 cycles in RESP while both requesters wait.
    a0 = 4'b0001; b0 = 4'b0010; op0 = 4'b1000;
    a1 = 4'b0111; b1 = 4'b1011; op1 = 4'b0000;
    req_valid = 2'b01;
    resp_ready = 1'b0;
    #1 checkVal("stall.grant", req_ready, 2'b01);
    step();
    req_valid = 2'b11;
    #1 checkVal("stall.execReady", req_ready, 2'b00);
    step();
    for (int i = 0; i < 5; i++) begin
      checkVal("stall.valid", resp_valid, 1'b1);
      checkVal("stall.res", resultado, 4'b0011);
      checkVal("stall.id", resp_id, 1'b0);
      checkVal("stall.reqReady", req_ready, 2'b00);
      if (i == 4) resp_ready = 1'b1;
      step();
    end
    checkVal("stall.idle", resp_valid, 1'b0);
    checkVal("stall.cnt0", ops_cnt0, 8'd4);
    checkVal("stall.rrGrant", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    step();
    checkVal("stall.id1", resp_id, 1'b1);
    checkVal("stall.res1", resultado, 4'b0011);
    step();
    checkVal("stall.cnt1", ops_cnt1, 8'd5);

    // Both requesters valid continuously straight after reset.
    rst = 1'b1;
    step();
    checkVal("rst2.cnt0", ops_cnt0, 8'h00);
    checkVal("rst2.cnt1", ops_cnt1, 8'h00);
    rst = 1'b0;
    a0 = 4'b0111; b0 = 4'b1011; op0 = 4'b0000;
    a1 = 4'b0111; b1 = 4'b1011; op1 = 4'b1000;
    req_valid = 2'b11;
    resp_ready = 1'b1;
    #1 checkVal("rr.firstGrant", req_ready, 2'b01);
    lastK = 0;
    nResp = 0;
    expId = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (resp_valid) begin
        checkVal("rr.id", resp_id, expId);
        checkVal("rr.res", resultado, expId ? 4'b0010 : 4'b0011);
        if (nResp > 0) checkVal("rr.gap", k - lastK, 3);
        lastK = k;
        expId = ~expId;
        nResp++;
      end
    end
    req_valid = 2'b00;
    checkVal("rr.count", nResp, 4);
    checkVal("rr.cnt0", ops_cnt0, 8'd2);
    checkVal("rr.cnt1", ops_cnt1, 8'd2);

    // Reset during EXEC aborts the operation and restores prio to 0.
    step();
    a0 = 4'b0001; b0 = 4'b0001; op0 = 4'b1000;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    #1 rst = 1'b1;
    #1;
    checkVal("abort.valid", resp_valid, 1'b0);
    checkVal("abort.cnt0", ops_cnt0, 8'h00);
    checkVal("abort.cnt1", ops_cnt1, 8'h00);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checkVal("abort.noResp", resp_valid, 1'b0);
    end
    req_valid = 2'b11;
    #1 checkVal("abort.grant0", req_ready, 2'b01);
    req_valid = 2'b00;

    // Counter saturation after more than 256 completions.
    step();
    a0 = 4'b0001; b0 = 4'b0001; op0 = 4'b1000;
    req_valid = 2'b01;
    resp_ready = 1'b1;
    for (int i = 0; i < 3 * 257; i++) step();
    req_valid = 2'b00;
    step();
    step();
    step();
    checkVal("sat.cnt0", ops_cnt0, 8'hFF);
    checkVal("sat.cnt1", ops_cnt1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/arbitro_alu.md
ARBITRO_ALU -- requirements
Module: arbitro_alu

Interface
REQ-001 Parameter: N, default 32, operand/result width in bits passed to the ALU instance.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  2  per-requester request strobe; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept; a request is taken when req_valid[i] & req_ready[i].
REQ-006 a0, b0 / a1, b1  input  N each  operands of requester 0 / 1.
REQ-007 op0 / op1  input  4 each  ALUControl code of requester 0 / 1.
REQ-008 resp_valid  output  1  response available.
REQ-009 resp_ready  input  1  consumer accepts response.
REQ-010 resp_id  output  1  requester index that owns the response.
REQ-011 resultado  output  N  registered ALU result.
REQ-012 flag_n, flag_z, flag_v, flag_c  output  1 each  registered ALU flags.
REQ-013 resp_err  output  1  high when the executed code was unsupported (4'b1110, 4'b1111).
REQ-014 ops_cnt0 / ops_cnt1  output  8 each  completed-operation counters per requester.

Function
REQ-015 Contains exactly one unidad_logico_aritmetica #(N) instance; its port order is (a, b, ALUControl, resultado, negativo, cero, overflow, carry), and its inputs are driven only from internal operand registers.
REQ-016 FSM states: IDLE, EXEC, RESP.
REQ-017 IDLE: if any req_valid, assert req_ready combinationally for the single winner only; on handshake, capture a, b, op and id, then go to EXEC.
REQ-018 Arbitration: round-robin; pointer prio (1 bit) names the preferred requester; after every grant, prio = ~granted id.
REQ-019 A lone requester is granted regardless of prio; with no valid request, the FSM stays in IDLE.
REQ-020 req_ready is 0 in EXEC and RESP.
REQ-021 EXEC (one cycle): register the ALU result and four flags; resp_err = (op >= 4'b1110); go to RESP.
REQ-022 When resp_err=1, resultado and all flags are registered as 0.
REQ-023 RESP: resp_valid=1; resultado, flags, resp_id and resp_err stay stable until resp_ready=1.
REQ-024 On the resp_valid & resp_ready cycle: increment ops_cnt[resp_id] and return to IDLE.
REQ-025 resp_valid is 0 in IDLE and EXEC.
REQ-026 Latency from request handshake (cycle t) to resp_valid: 2 cycles (visible at t+2).
REQ-027 Throughput is at most one operation per 3 cycles; the next grant is no earlier than the cycle after response handshake.
REQ-028 ops_cnt* saturate at 8'hFF; no wrap-around.
REQ-029 Error operations also count as completed.
REQ-030 Requests held while not granted keep their operands; the arbiter never drops or reorders an accepted request.

Reset
REQ-031 rst=1 forces, asynchronously:
 - state=IDLE, prio=0
 - resp_valid=0, req_ready=0
 - resultado=0, all flags=0, resp_id=0, resp_err=0
 - ops_cnt0=ops_cnt1=0
 - operand registers=0
REQ-032 Reset in EXEC or RESP aborts the operation; no response is produced and no counter increments.
REQ-033 The first grant after reset release goes to requester 0 if both request.

Verification (N=4)
REQ-034 Req0 only: a0=0111, b0=1011, op0=0000 -> req_ready=01 at t, resp_valid at t+2, resultado=0011, resp_id=0, ops_cnt0=1 after accept.
REQ-035 Req1 only: op1=1000, a1=0111, b1=1011 -> resultado=0010, flag_c=1, flag_z=0; then op1=1001 with the same operands -> resultado=1100, flag_n=1, flag_v=1.
REQ-036 Both valid continuously after reset, resp_ready=1 -> grants alternate 0,1,0,1; each response arrives 3 cycles after the previous one.
REQ-037 op0=1111 -> resp_err=1, resultado=0000, all flags 0, ops_cnt0 increments.
REQ-038 resp_ready held 0 for 5 cycles in RESP -> outputs stable, req_ready=00 throughout; release -> IDLE next cycle.
REQ-039 rst pulsed during EXEC -> resp_valid never rises, counters=0, next simultaneous request is granted to requester 0.
